// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths and state encoding for the memory bus arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        CPU_OWN   = 2'd0,
        DBG_ISSUE = 2'd1,
        DBG_READ  = 2'd2,
        DBG_ACK   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - CPU, debug and memory control signals of the arbiter
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              cpu_cs;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_cs, mem_we, mem_addr
    );

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_cs, mem_we, mem_addr
    );

endinterface

// File: rtl/mem_arb_wait_ctr.sv
// rtl/mem_arb_wait_ctr.sv - saturating wait counter that flags when a debug request must be forced
module mem_arb_wait_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q;

    // Holds at LAST so a long CPU burst cannot wrap the count back to zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory between the CPU (priority) and the debug/display port
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 8
) (
    input  logic               CLK,
    input  logic               RST,
    mem_bus_arbiter_if.slave   bus,
    inout  wire [DATA_W-1:0]   Mem_Bus
);

    arb_state_e        state_q;
    logic              lat_we_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              dbg_ack_q;
    logic              cpu_stall_q;

    logic              wait_expired;
    logic              wait_inc;
    logic              wait_clr;
    logic              grant;
    logic              cpu_owns;
    logic [DATA_W-1:0] wr_data_d;

    assign cpu_owns = (state_q == CPU_OWN);
    assign grant    = cpu_owns && bus.dbg_req && (!bus.cpu_cs || wait_expired);
    assign wait_inc = cpu_owns && bus.dbg_req && bus.cpu_cs;
    assign wait_clr = !cpu_owns || !bus.dbg_req || grant;

    mem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (wait_clr),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    // Stall and ack are registered alongside the state so they line up with it exactly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= CPU_OWN;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            dbg_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
            cpu_stall_q <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (state_q)
                CPU_OWN: begin
                    if (grant) begin
                        lat_we_q    <= bus.dbg_we;
                        lat_addr_q  <= bus.dbg_addr;
                        lat_wdata_q <= bus.dbg_wdata;
                        cpu_stall_q <= 1'b1;
                        state_q     <= DBG_ISSUE;
                    end
                end
                DBG_ISSUE: begin
                    if (lat_we_q) begin
                        cpu_stall_q <= 1'b0;
                        dbg_ack_q   <= 1'b1;
                        state_q     <= DBG_ACK;
                    end else begin
                        state_q     <= DBG_READ;
                    end
                end
                DBG_READ: begin
                    dbg_rdata_q <= Mem_Bus;
                    cpu_stall_q <= 1'b0;
                    dbg_ack_q   <= 1'b1;
                    state_q     <= DBG_ACK;
                end
                DBG_ACK: begin
                    state_q <= CPU_OWN;
                end
                default: begin
                    cpu_stall_q <= 1'b0;
                    state_q     <= CPU_OWN;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_cs   = bus.cpu_cs;
        bus.mem_we   = bus.cpu_we;
        bus.mem_addr = bus.cpu_addr;
        wr_data_d    = bus.cpu_wdata;
        case (state_q)
            DBG_ISSUE: begin
                bus.mem_cs   = 1'b1;
                bus.mem_we   = lat_we_q;
                bus.mem_addr = lat_addr_q;
                wr_data_d    = lat_wdata_q;
            end
            DBG_READ: begin
                bus.mem_cs   = 1'b1;
                bus.mem_we   = 1'b0;
                bus.mem_addr = lat_addr_q;
            end
            default: ;
        endcase
    end

    // Single bus driver: the memory only drives on reads, so there is never contention.
    assign Mem_Bus = (bus.mem_cs && bus.mem_we) ? wr_data_d : {DATA_W{1'bz}};

    assign bus.cpu_rdata = Mem_Bus;
    assign bus.cpu_stall = cpu_stall_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_rdata = dbg_rdata_q;

endmodule
